// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction
// memory itself, so both agree on depth, index width and frame start byte.
package imem_loader_pkg;

    localparam int         IMEM_DEPTH   = 32;
    localparam int         IMEM_ADDR_W  = 5;
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: byte source / memory side, slave: the loader.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: MAGIC, N, 4*N little-endian data bytes, XOR
// checksum of the data bytes. Writes each assembled word to the instruction
// memory and holds the core in reset for the duration of the frame.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | hunting for MAGIC, other bytes dropped
//  COUNT   | receiving word count N
//  DATA    | assembling a word from 4 bytes, updating checksum
//  WRITE   | one-cycle mem_we pulse for the assembled word
//  CHECK   | receiving checksum byte
//  DONE    | one cycle: done pulse if frame good, release core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH  = IMEM_DEPTH,
    parameter int         ADDR_W = IMEM_ADDR_W,
    parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    // Word count / index need one extra bit so that N == DEPTH is representable.
    localparam int         CNT_W   = ADDR_W + 1;
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    loader_state_t     state;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_nxt;
    logic [1:0]        bcnt;
    logic [7:0]        csum;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              accept;

    assign idx_nxt = idx + 1'b1;

    // Ready is a decode of the state, forced low while reset is asserted.
    assign bus.in_ready = !reset && (state == S_IDLE  || state == S_COUNT ||
                                     state == S_DATA  || state == S_CHECK);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q};
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;

    // Frame FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            n_q      <= '0;
            idx      <= '0;
            bcnt     <= '0;
            csum     <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && bus.in_data == MAGIC) begin
                        state    <= S_COUNT;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        if (bus.in_data == 8'd0) begin
                            csum  <= '0;
                            state <= S_CHECK;
                        end else if (bus.in_data > DEPTH_B) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            n_q   <= bus.in_data[CNT_W-1:0];
                            idx   <= '0;
                            bcnt  <= '0;
                            csum  <= '0;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ bus.in_data;
                        bcnt <= bcnt + 1'b1;
                        case (bcnt)
                            2'd0: word_q[7:0]   <= bus.in_data;
                            2'd1: word_q[15:8]  <= bus.in_data;
                            2'd2: word_q[23:16] <= bus.in_data;
                            2'd3: begin
                                wdata_q <= {bus.in_data, word_q};
                                addr_q  <= idx[ADDR_W-1:0];
                                we_q    <= 1'b1;
                                state   <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    we_q  <= 1'b0;
                    idx   <= idx_nxt;
                    bcnt  <= '0;
                    state <= (idx_nxt == n_q) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (accept) begin
                        if (bus.in_data != csum)
                            err <= 1'b1;
                        done     <= (bus.in_data == csum) && !err;
                        cpu_hold <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
